// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt manager/reader pair: line count, id width
// and the reader's sequencing states.
package interrupt_pkg;

    localparam int NUM_LINES = 8;
    localparam int ID_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } rd_state_e;

endpackage

// File: rtl/interrupt_reader_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable idle
// value loaded on reset.
module synchronizer #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/interrupt_reader.sv
// Reads latched interrupt lines from the manager with a timed n_rd strobe, keeps
// them pending and dispatches them one at a time, lowest index first.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for synchronized n_int to go low
// ST_STROBE  | n_rd low for RD_CYCLES clocks; capture dat in the last one
// ST_HOLDOFF | n_rd high for GAP_CYCLES clocks while n_int settles
module interrupt_reader
    import interrupt_pkg::*;
#(
    parameter int RD_CYCLES  = 3,
    parameter int GAP_CYCLES = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 n_int_i,
    input  logic [NUM_LINES-1:0] dat_i,
    output logic                 n_rd_o,
    input  logic [NUM_LINES-1:0] mask_i,
    output logic                 irq_valid_o,
    output logic [ID_W-1:0]      irq_id_o,
    input  logic                 irq_ready_i,
    output logic [NUM_LINES-1:0] pending_o,
    output logic [NUM_LINES-1:0] lost_o,
    input  logic                 lost_clr_i,
    output logic                 busy_o
);

    logic                 n_int_s;
    logic [NUM_LINES-1:0] dat_s;

    synchronizer #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_int (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (n_int_i),
        .q_o   (n_int_s)
    );

    synchronizer #(.WIDTH(NUM_LINES), .RST_VAL('0)) u_sync_dat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (dat_i),
        .q_o   (dat_s)
    );

    rd_state_e            state_q;
    logic [3:0]           cnt_q;
    logic                 n_rd_q;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic [NUM_LINES-1:0] lost_q, lost_d;
    logic                 irq_valid_q;
    logic [ID_W-1:0]      irq_id_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_rd_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!n_int_s) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= 4'(RD_CYCLES - 1);
                        n_rd_q  <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_HOLDOFF;
                        cnt_q   <= 4'(GAP_CYCLES - 1);
                        n_rd_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == 4'd0) state_q <= ST_IDLE;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    n_rd_q  <= 1'b1;
                end
            endcase
        end
    end

    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_LINES-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--)
            if (v[i]) lowest_idx = ID_W'(i);
    endfunction

    logic                 capture;
    logic                 handshake;
    logic [NUM_LINES-1:0] cap_bits;
    logic [NUM_LINES-1:0] clr_bits;
    logic [NUM_LINES-1:0] enabled;

    // A capture of the bit being handed off in the same cycle is a fresh event,
    // so set overrides the clear and it is not counted as lost.
    always_comb begin
        capture   = (state_q == ST_STROBE) && (cnt_q == 4'd0);
        handshake = irq_valid_q & irq_ready_i;
        cap_bits  = capture ? dat_s : '0;
        clr_bits  = '0;
        if (handshake) clr_bits[irq_id_q] = 1'b1;
        pending_d = (pending_q & ~clr_bits) | cap_bits;
        lost_d    = (lost_q & ~{NUM_LINES{lost_clr_i}}) | (cap_bits & pending_q & ~clr_bits);
        enabled   = pending_q & mask_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            lost_q      <= '0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            pending_q <= pending_d;
            lost_q    <= lost_d;
            if (handshake) begin
                irq_valid_q <= 1'b0;
            end else if (!irq_valid_q && (|enabled)) begin
                irq_valid_q <= 1'b1;
                irq_id_q    <= lowest_idx(enabled);
            end
        end
    end

    assign n_rd_o      = n_rd_q;
    assign irq_valid_o = irq_valid_q;
    assign irq_id_o    = irq_id_q;
    assign pending_o   = pending_q;
    assign lost_o      = lost_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
